breathe_ramp: RTL and testbench
===============================

Name: breathe_ramp

Overview:
- Generates the duty-cycle value that feeds the `compare` input of the existing 8-bit `pwm` stage; replaces the free-running counter on the LED path.
- Produces a "breathing" profile in four stages: linear rise from `min_level` to `max_level`, hold high, linear fall, hold low, repeat.
- Each step is timed by an internal prescaler. One-cycle `update` strobe marks every value change.

Parameters:
- CTR_LEN, 8, width of `value`, `min_level` and `max_level`; matches `pwm` CTR_LEN.
- STEP_DIV, 50000, clk cycles per step tick (1 kHz at 50 MHz); legal range >= 2.
- HOLD_HI_STEPS, 64, ticks spent in HOLD_HI; legal range >= 1.
- HOLD_LO_STEPS, 32, ticks spent in HOLD_LO; legal range >= 1.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  Synchronous, active-low reset.
- en  in  1  Run enable; low freezes all state.
- min_level  in  CTR_LEN  Floor of the ramp.
- max_level  in  CTR_LEN  Ceiling of the ramp.
- value  out  CTR_LEN  Registered duty value to `pwm.compare`.
- update  out  1  One-cycle pulse in the cycle `value` changes.
- phase  out  3  Current state: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

Behaviour:
- **Clock and reset:** one clock. Reset is synchronous and active-low (`rst_n` sampled on posedge `clk`).
- **Reset values:** `value`=0, `update`=0, `phase`=IDLE, prescaler=0, hold counter=0. Reset mid-operation aborts immediately to these values.
- **Tick generation:**
  - Prescaler counts 0..STEP_DIV-1 while `en`=1, then wraps to 0.
  - tick = (`en` && prescaler==STEP_DIV-1).
  - While `en`=0: prescaler, state, `value` and hold counter hold; `update`=0.
- **IDLE:** when `en`=1, next cycle `value`<=`min_level`, `phase`<=RISE, prescaler<=0. No `update` pulse on this load.
- **RISE** (on tick):
  - If `value` >= `max_level`: go to HOLD_HI, hold counter<=0, `value` unchanged.
  - Else `value`<=`value`+1 and `update`=1.
- **HOLD_HI** (on tick):
  - If hold counter == HOLD_HI_STEPS-1: go to FALL.
  - Else hold counter +1.
- **FALL** (on tick):
  - If `value` <= `min_level`: go to HOLD_LO, hold counter<=0.
  - Else `value`<=`value`-1 and `update`=1.
- **HOLD_LO** (on tick): same rule as HOLD_HI using HOLD_LO_STEPS, then go to RISE.
- **Timing:** `update` is registered and asserted in the same cycle the new `value` first appears. Latency from tick to new `value` is 1 clk.
- **No wrap-around:** the guards make +1 at all-ones and -1 at zero impossible.
- **Degenerate range:** `max_level` <= `min_level` keeps `value` constant. States still cycle RISE→HOLD_HI→FALL→HOLD_LO; no `update` pulses.
- **Live level changes:**
  - `min_level`/`max_level` are sampled at each tick (not latched).
  - `value` above a newly lowered `max_level` during RISE goes to HOLD_HI, then falls normally.
- **`en` deasserted mid-ramp:** pauses only. Resumes from the same prescaler count and state.
- **Unused code:** `phase` codes 5-7 unreachable; if entered, recover to IDLE next cycle.

Decomposition:
- Shared package/include holds:
  - the phase encoding localparams (IDLE..HOLD_LO, 3 bits);
  - the default STEP_DIV for 50 MHz.
- One natural sub-module: `step_prescaler` (params DIV; ports `clk`, `rst_n`, `en`, `tick`), reusable by other LED effects.
- Hold counter width = clog2(max(HOLD_HI_STEPS, HOLD_LO_STEPS)) + 1.

Test Plan (STEP_DIV=4, HOLD_HI_STEPS=2, HOLD_LO_STEPS=1, CTR_LEN=8 unless noted):
- **Reset:** `rst_n`=0 for 3 cycles with `en`=1 -> `value`=0, `update`=0, `phase`=0. Release, one cycle later -> `phase`=1, `value`=`min_level`.
- **Full cycle:** `min_level`=0, `max_level`=3.
  - `value` steps 1,2,3 on ticks 1-3 (every 4 clk), each with a single-cycle `update`.
  - HOLD_HI on tick 4; FALL on tick 6; 2,1,0 on ticks 7-9.
  - HOLD_LO on tick 10; RISE on tick 11; `value`=1 on tick 12.
- **Pause:** drop `en` for 10 cycles mid-RISE at `value`=2 -> `value`, `phase` and prescaler frozen, no `update`. Next step arrives exactly 4-(elapsed count) cycles after `en` returns.
- **Ceiling/wrap:** CTR_LEN=8, `min_level`=254, `max_level`=255 -> `value` reaches 255, never 0. Then falls to 254 and holds.
- **Degenerate and live change:**
  - `min_level`=`max_level`=10 -> `value` stays 10 through 3 full phase cycles with zero `update` pulses.
  - Then during RISE at `value`=8, set `max_level`=5 -> HOLD_HI next tick, then 7,6,5...
- **Mid-ramp reset:** assert `rst_n`=0 in FALL at `value`=2 -> next cycle `value`=0, `phase`=IDLE, `update`=0.

Source files
------------

// File: rtl/breathe_ramp_pkg.sv
// Shared definitions for the breathing-LED duty ramp: phase encoding and
// default step timing for a 50 MHz system clock.
package breathe_ramp_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_RISE    = 3'd1,
        PH_HOLD_HI = 3'd2,
        PH_FALL    = 3'd3,
        PH_HOLD_LO = 3'd4
    } phase_e;

    // 50 MHz / 50000 = 1 kHz step rate
    localparam int DEFAULT_STEP_DIV = 50000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/breathe_ramp_step_prescaler.sv
// Free-running step prescaler: one-cycle tick every DIV enabled clocks.
// Count and tick freeze while en is low.
module step_prescaler
    import breathe_ramp_pkg::*;
#(
    parameter int DIV = DEFAULT_STEP_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_count;

    assign tick = en && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= tick ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/breathe_ramp.sv
// Breathing duty-cycle generator for the pwm compare input: rise, hold high,
// fall, hold low, repeat, one step per prescaler tick.
module breathe_ramp
    import breathe_ramp_pkg::*;
#(
    parameter int CTR_LEN       = 8,
    parameter int STEP_DIV      = DEFAULT_STEP_DIV,
    parameter int HOLD_HI_STEPS = 64,
    parameter int HOLD_LO_STEPS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CTR_LEN-1:0] min_level,
    input  logic [CTR_LEN-1:0] max_level,
    output logic [CTR_LEN-1:0] value,
    output logic               update,
    output logic [2:0]         phase
);

    localparam int HOLD_W = $clog2(max_int(HOLD_HI_STEPS, HOLD_LO_STEPS)) + 1;
    localparam logic [HOLD_W-1:0] HI_LAST = HOLD_W'(HOLD_HI_STEPS - 1);
    localparam logic [HOLD_W-1:0] LO_LAST = HOLD_W'(HOLD_LO_STEPS - 1);

    phase_e              r_phase;
    logic [CTR_LEN-1:0]  r_value;
    logic                r_update;
    logic [HOLD_W-1:0]   r_hold;
    logic                w_tick;
    logic                w_active;
    logic                w_pre_rst_n;

    // Prescaler sits cleared outside the ramp phases so RISE always starts
    // a full step period after the IDLE load.
    assign w_active = (r_phase == PH_RISE) || (r_phase == PH_HOLD_HI) ||
                      (r_phase == PH_FALL) || (r_phase == PH_HOLD_LO);
    assign w_pre_rst_n = rst_n && w_active;

    step_prescaler #(
        .DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (w_pre_rst_n),
        .en    (en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase  <= PH_IDLE;
            r_value  <= '0;
            r_update <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_update <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (en) begin
                        r_value <= min_level;
                        r_phase <= PH_RISE;
                    end
                end
                PH_RISE: begin
                    if (w_tick) begin
                        if (r_value >= max_level) begin
                            r_phase <= PH_HOLD_HI;
                            r_hold  <= '0;
                        end else begin
                            r_value  <= r_value + CTR_LEN'(1);
                            r_update <= 1'b1;
                        end
                    end
                end
                PH_HOLD_HI: begin
                    if (w_tick) begin
                        if (r_hold == HI_LAST) r_phase <= PH_FALL;
                        else                   r_hold  <= r_hold + HOLD_W'(1);
                    end
                end
                PH_FALL: begin
                    if (w_tick) begin
                        if (r_value <= min_level) begin
                            r_phase <= PH_HOLD_LO;
                            r_hold  <= '0;
                        end else begin
                            r_value  <= r_value - CTR_LEN'(1);
                            r_update <= 1'b1;
                        end
                    end
                end
                PH_HOLD_LO: begin
                    if (w_tick) begin
                        if (r_hold == LO_LAST) r_phase <= PH_RISE;
                        else                   r_hold  <= r_hold + HOLD_W'(1);
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign value  = r_value;
    assign update = r_update;
    assign phase  = r_phase;

endmodule

// File: tb/tb_breathe_ramp.sv
// Directed plus randomized bench for breathe_ramp against a tick-level
// behavioural model of the breathing profile.
module tb_breathe_ramp;

    localparam int CTR_LEN  = 8;
    localparam int STEP_DIV = 4;
    localparam int HOLD_HI  = 2;
    localparam int HOLD_LO  = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [CTR_LEN-1:0] min_level;
    logic [CTR_LEN-1:0] max_level;
    logic [CTR_LEN-1:0] value;
    logic               update;
    logic [2:0]         phase;

    int n_tests = 0;
    int n_fail  = 0;
    int n_upd   = 0;
    int seen_zero;

    // Model: stage 0 idle, 1 rise, 2 hold high, 3 fall, 4 hold low
    int m_value = 0;
    int m_stage = 0;
    int m_upd   = 0;
    int m_en_cycles = 0;
    int m_ticks_left = 0;

    breathe_ramp #(
        .CTR_LEN       (CTR_LEN),
        .STEP_DIV      (STEP_DIV),
        .HOLD_HI_STEPS (HOLD_HI),
        .HOLD_LO_STEPS (HOLD_LO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .min_level (min_level),
        .max_level (max_level),
        .value     (value),
        .update    (update),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic s_rst, input logic s_en,
                              input int s_min, input int s_max);
        m_upd = 0;
        if (!s_rst) begin
            m_value = 0; m_stage = 0; m_en_cycles = 0; m_ticks_left = 0;
        end else if (m_stage == 0) begin
            if (s_en) begin
                m_value = s_min; m_stage = 1; m_en_cycles = 0;
            end
        end else if (s_en) begin
            m_en_cycles++;
            if (m_en_cycles == STEP_DIV) begin
                m_en_cycles = 0;
                case (m_stage)
                    1: if (m_value >= s_max) begin m_stage = 2; m_ticks_left = HOLD_HI; end
                       else begin m_value++; m_upd = 1; end
                    2: begin m_ticks_left--; if (m_ticks_left == 0) m_stage = 3; end
                    3: if (m_value <= s_min) begin m_stage = 4; m_ticks_left = HOLD_LO; end
                       else begin m_value--; m_upd = 1; end
                    default: begin m_ticks_left--; if (m_ticks_left == 0) m_stage = 1; end
                endcase
            end
        end
    endtask

    // One clock: inputs seen at the edge feed the model, outputs checked 1 ns later
    task automatic cyc();
        logic s_rst, s_en;
        int s_min, s_max;
        s_rst = rst_n; s_en = en; s_min = int'(min_level); s_max = int'(max_level);
        @(posedge clk);
        #1;
        model_step(s_rst, s_en, s_min, s_max);
        chk("value", int'(value), m_value);
        chk("update", int'(update), m_upd);
        chk("phase", int'(phase), m_stage);
        if (update) n_upd++;
        if (value == '0) seen_zero++;
    endtask

    task automatic do_reset(input int lo, input int hi);
        rst_n = 1'b0; en = 1'b1;
        min_level = CTR_LEN'(lo); max_level = CTR_LEN'(hi);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int k;
        rst_n = 1'b0; en = 1'b1; min_level = 8'd7; max_level = 8'd7;

        // Reset held three cycles with en high, then release
        cyc(); cyc(); cyc();
        chk("reset_value", int'(value), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_update", int'(update), 0);
        rst_n = 1'b1;
        cyc();
        chk("release_phase", int'(phase), 1);
        chk("release_value", int'(value), 7);

        // Full cycle 0..3, through hold low and back to value 1
        do_reset(0, 3);
        n_upd = 0;
        for (k = 0; k < 12 * STEP_DIV; k++) cyc();
        chk("full_cycle_value", int'(value), 1);
        chk("full_cycle_phase", int'(phase), 1);
        chk("full_cycle_updates", n_upd, 7);

        // Pause mid-rise at value 2
        for (k = 0; k < 100 && !(m_stage == 1 && m_value == 2); k++) cyc();
        chk("reach_rise_2", (m_stage == 1 && m_value == 2) ? 1 : 0, 1);
        cyc();
        en = 1'b0; n_upd = 0;
        for (k = 0; k < 10; k++) cyc();
        chk("pause_value", int'(value), 2);
        chk("pause_updates", n_upd, 0);
        en = 1'b1;
        for (k = 0; k < 3 * STEP_DIV; k++) cyc();

        // Ceiling: 254..255 never wraps to zero
        do_reset(254, 255);
        seen_zero = 0;
        for (k = 0; k < 200 && m_stage != 4; k++) cyc();
        chk("ceiling_hold_lo", int'(phase), 4);
        chk("ceiling_value", int'(value), 254);
        chk("ceiling_no_zero", seen_zero, 0);

        // Degenerate range: three full phase cycles, no updates
        do_reset(10, 10);
        n_upd = 0;
        for (k = 0; k < 15 * STEP_DIV; k++) cyc();
        chk("degen_value", int'(value), 10);
        chk("degen_updates", n_upd, 0);
        chk("degen_phase", int'(phase), 1);

        // Live ceiling drop during rise at value 8
        do_reset(0, 20);
        for (k = 0; k < 200 && !(m_stage == 1 && m_value == 8); k++) cyc();
        chk("reach_rise_8", (m_stage == 1 && m_value == 8) ? 1 : 0, 1);
        max_level = 8'd5; min_level = 8'd5;
        for (k = 0; k < STEP_DIV; k++) cyc();
        chk("live_hold_hi", int'(phase), 2);
        for (k = 0; k < 200 && m_stage != 4; k++) cyc();
        chk("live_floor_value", int'(value), 5);

        // Mid-ramp reset in FALL at value 2
        do_reset(0, 4);
        for (k = 0; k < 300 && !(m_stage == 3 && m_value == 2); k++) cyc();
        chk("reach_fall_2", (m_stage == 3 && m_value == 2) ? 1 : 0, 1);
        rst_n = 1'b0;
        cyc();
        chk("midreset_value", int'(value), 0);
        chk("midreset_phase", int'(phase), 0);
        chk("midreset_update", int'(update), 0);
        rst_n = 1'b1;

        // Randomized enable and live level changes
        for (k = 0; k < 600; k++) begin
            en = ($urandom_range(0, 7) != 0);
            if (k % 60 == 0) begin
                min_level = CTR_LEN'($urandom_range(0, 12));
                max_level = CTR_LEN'($urandom_range(0, 20));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
